// File: rtl/orv64_fetch_requester_pkg.sv
// Shared types for the orv64 IF<->IC fetch path: virtual address, request/response
// structs and the fetch requester state encoding.
package orv64_fetch_requester_pkg;

  localparam int VADDR_W         = 39;
  localparam int FETCH_BYTES_DEF = 4;

  typedef logic [VADDR_W-1:0] orv64_vaddr_t;

  typedef struct packed {
    logic         en;
    orv64_vaddr_t pc;
  } orv64_if2ic_t;

  typedef struct packed {
    logic         valid;
    orv64_vaddr_t vaddr;
    logic [31:0]  inst;
  } orv64_ic2if_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } orv64_fetch_state_e;

endpackage

// File: rtl/orv64_fetch_queue.sv
// Synchronous FIFO of icache responses feeding decode; head is zero whenever the queue
// is empty so the output never shows stale entries.
module orv64_fetch_queue
  import orv64_fetch_requester_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  orv64_ic2if_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic          valid,
  output orv64_ic2if_t  head,
  output logic [CW-1:0] count
);

  orv64_ic2if_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_eff;
  logic          push_eff;

  assign valid    = (count != '0);
  assign pop_eff  = pop && valid;
  // a push into a full queue is only taken when the head leaves in the same cycle
  assign push_eff = push && !clear && ((count < CW'(DEPTH)) || pop_eff);
  assign head     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/orv64_fetch_requester.sv
// IF side of the IF<->IC interface: issues sequential fetches under a credit limit,
// queues in-order responses for decode, and handles redirect and fence.i drain/flush.
module orv64_fetch_requester
  import orv64_fetch_requester_pkg::*;
#(
  parameter int FQ_DEPTH    = 4,
  parameter int MAX_OUTST   = 2,
  parameter int FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  orv64_vaddr_t boot_pc,
  input  logic         redirect_valid,
  input  orv64_vaddr_t redirect_pc,
  input  logic         fence_i_valid,
  input  orv64_vaddr_t fence_i_pc,
  output orv64_if2ic_t if2ic,
  input  logic         ic_ready,
  input  orv64_ic2if_t ic2if,
  output logic         itb_flush,
  output logic         fq_valid,
  output orv64_ic2if_t fq_data,
  input  logic         fq_pop,
  output logic         seq_err
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int EW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  orv64_fetch_state_e state, state_nxt;
  orv64_vaddr_t       pc_q, pc_nxt;
  logic               en_q, en_nxt;
  logic [CW-1:0]      outst_q, outst_nxt;
  logic [CW-1:0]      drop_q, drop_nxt;
  logic [CW-1:0]      fq_count, fq_cnt_nxt;

  logic accept, fence, redir;
  logic resp_orphan, resp_drop, resp_live, resp_counted;
  logic fq_push, fq_pop_eff, fq_clear;
  logic exp_push, exp_pop, seq_err_set;

  orv64_vaddr_t  exp_mem [MAX_OUTST];
  logic [EW-1:0] exp_rd, exp_wr;

  function automatic logic [EW-1:0] exp_inc(input logic [EW-1:0] p);
    return (p == EW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept       = en_q && ic_ready;
  assign fence        = fence_i_valid && (state == RUN);
  assign redir        = redirect_valid && !fence && ((state == RUN) || (state == DRAIN));
  assign resp_orphan  = ic2if.valid && (outst_q == '0);
  assign resp_counted = ic2if.valid && !resp_orphan;
  assign resp_drop    = resp_counted && (drop_q != '0);
  assign resp_live    = resp_counted && (drop_q == '0);
  assign fq_push      = resp_live && !redir;
  assign fq_pop_eff   = fq_pop && fq_valid;
  assign fq_clear     = redir || (state == FLUSH);
  assign exp_push     = accept && !redir;
  assign exp_pop      = resp_live && !redir;
  assign seq_err_set  = resp_orphan || (exp_pop && (ic2if.vaddr != exp_mem[exp_rd]));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fence) state_nxt = DRAIN;
      DRAIN:   if (outst_q == '0) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    itb_flush = (state == FLUSH);
    if2ic.en  = en_q;
    if2ic.pc  = pc_q;
  end

  always_comb begin
    outst_nxt  = outst_q + CW'(accept) - CW'(resp_counted);
    // on redirect every request still in flight, including one accepted now, is stale
    drop_nxt   = redir ? outst_nxt : (drop_q - CW'(resp_drop));
    fq_cnt_nxt = fq_clear ? '0 : (fq_count + CW'(fq_push) - CW'(fq_pop_eff));

    pc_nxt = pc_q;
    if ((state == IDLE) && start) pc_nxt = boot_pc;
    else if (fence)               pc_nxt = fence_i_pc;
    else if (redir)               pc_nxt = redirect_pc;
    else if (accept)              pc_nxt = pc_q + VADDR_W'(FETCH_BYTES);

    en_nxt = (state_nxt == RUN) && !fence && !redir &&
             (outst_nxt < CW'(MAX_OUTST)) &&
             ((SW'(outst_nxt) + SW'(fq_cnt_nxt)) < SW'(FQ_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      en_q    <= 1'b0;
      outst_q <= '0;
      drop_q  <= '0;
      seq_err <= 1'b0;
    end else begin
      pc_q    <= pc_nxt;
      en_q    <= en_nxt;
      outst_q <= outst_nxt;
      drop_q  <= drop_nxt;
      if (seq_err_set) seq_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redir) begin
      exp_rd <= '0;
      exp_wr <= '0;
    end else begin
      if (exp_push) exp_wr <= exp_inc(exp_wr);
      if (exp_pop)  exp_rd <= exp_inc(exp_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (exp_push) exp_mem[exp_wr] <= pc_q;
  end

  orv64_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (ic2if),
    .pop       (fq_pop),
    .clear     (fq_clear),
    .valid     (fq_valid),
    .head      (fq_data),
    .count     (fq_count)
  );

endmodule
